// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared FSM states, stack command codes and requester index type
package stack_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPT, ST_FLUSH} state_t;
  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_IDLE = 2'b10} stk_op_t;
  typedef logic req_id_t;
endpackage

// File: rtl/stack_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ties go to the requester not granted last
import stack_arb_pkg::*;
module rr_arb2 (
  input  logic clk,
  input  logic clr,
  input  logic v0,
  input  logic v1,
  input  logic en,
  output logic gnt
);
  req_id_t last_q;
  // tie breaks against the previous winner, a lone requester always wins
  always_comb gnt = (v0 && v1) ? ~last_q : v1;
  // remember the winner of every accepted request
  always_ff @(posedge clk)
    if (clr) last_q <= 1'b1;
    else if (en) last_q <= gnt;
endmodule

// File: rtl/stack_arb.sv
// stack_arb: arbitrates two push/pop requesters onto an external stack command port; optional STACK_ARB_ERRCNT_EN adds a saturating error counter
import stack_arb_pkg::*;
module stack_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             stk_en,
  output logic [1:0]       stk_con,
  output logic [WIDTH-1:0] stk_din,
  output logic             stk_clr_n,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             full,
  output logic             empty,
  output logic [7:0]       err_cnt
);
  localparam logic [DEPTH:0] cap = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] one = (DEPTH+1)'(1);
  state_t state, state_n;
  logic [DEPTH:0] occ;
  stk_op_t op_q;
  logic [WIDTH-1:0] data_q, win_data;
  req_id_t id_q, gnt;
  logic accept, win_pop, bad;
  rr_arb2 u_arb (.clk(clk), .clr(clr), .v0(req0_valid), .v1(req1_valid), .en(accept), .gnt(gnt));
  assign full  = occ == cap;
  assign empty = occ == '0;
  // accept/grant, next state and stack command decode
  always_comb begin
    accept     = state == ST_IDLE && !clr && !flush && (req0_valid || req1_valid);
    win_pop    = gnt ? req1_op : req0_op;
    win_data   = gnt ? req1_data : req0_data;
    bad        = win_pop ? empty : full;
    req0_ready = accept && !gnt;
    req1_ready = accept && gnt;
    state_n    = state == ST_IDLE ? (flush ? ST_FLUSH : (accept && !bad ? ST_ISSUE : ST_IDLE))
               : (state == ST_ISSUE && op_q == OP_POP) ? ST_CAPT : ST_IDLE;
    stk_en     = state == ST_ISSUE && !clr;
    stk_con    = stk_en ? op_q : OP_IDLE;
    stk_din    = (stk_en && op_q == OP_PUSH) ? data_q : '0;
    stk_clr_n  = !(clr || state == ST_FLUSH);
  end
  // state, latched request, occupancy and registered response
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      occ       <= '0;
      op_q      <= OP_IDLE;
      data_q    <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= (accept && bad) || (state == ST_ISSUE && op_q == OP_PUSH) || state == ST_CAPT;
      rsp_err   <= accept && bad;
      rsp_id    <= accept ? gnt : id_q;
      rsp_data  <= state == ST_CAPT ? stk_dout : '0;
      occ       <= state == ST_FLUSH ? '0
                 : state == ST_ISSUE ? (op_q == OP_POP ? occ - one : occ + one) : occ;
      if (accept) begin
        op_q   <= win_pop ? OP_POP : OP_PUSH;
        data_q <= win_data;
        id_q   <= gnt;
      end
    end
  end
`ifdef STACK_ARB_ERRCNT_EN
  logic [7:0] err_q;
  // count rejected operations, holding at the maximum
  always_ff @(posedge clk)
    if (clr) err_q <= '0;
    else if (rsp_valid && rsp_err && err_q != 8'hff) err_q <= err_q + 8'd1;
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_stack_arb.sv
// tb_stack_arb: randomized scoreboard bench for stack_arb with an external stack model
module tb_stack_arb;
  localparam int W = 8;
  logic clk = 0, clr = 1, flush = 0, v0 = 0, v1 = 0, op0 = 0, op1 = 0;
  logic [W-1:0] d0 = '0, d1 = '0, stk_dout = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, stk_en, stk_clr_n, full, empty;
  logic [W-1:0] rsp_data, stk_din;
  logic [1:0] stk_con;
  logic [7:0] err_cnt;

  stack_arb #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .clr(clr), .flush(flush),
    .req0_valid(v0), .req0_op(op0), .req0_data(d0),
    .req1_valid(v1), .req1_op(op1), .req1_data(d1),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .stk_en(stk_en), .stk_con(stk_con), .stk_din(stk_din), .stk_clr_n(stk_clr_n),
    .stk_dout(stk_dout), .full(full), .empty(empty), .err_cnt(err_cnt));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external 4-entry stack reacting to the command port
  logic [W-1:0] mem [4];
  logic [2:0] sp = '0;
  always @(posedge clk)
    if (!stk_clr_n) sp <= '0;
    else if (stk_en && stk_con == 2'b00 && sp < 3'd4) begin mem[sp[1:0]] <= stk_din; sp <= sp + 3'd1; end
    else if (stk_en && stk_con == 2'b01 && sp != 3'd0) begin stk_dout <= mem[sp[1:0] - 2'd1]; sp <= sp - 3'd1; end

  typedef struct {int at; logic id; logic err; logic [W-1:0] data;} exp_t;
  exp_t sb[$];
  logic [W-1:0] ref_stk[$];
  int total = 0, bad = 0, free_at = 0, issue_at = -1, flush_at = -1, n_err = 0;
  logic last = 1'b1, iss_op = 1'b0;
  logic [W-1:0] iss_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // one clock of stimulus: drive, check combinational outputs against the model, then advance the model
  task automatic step(input logic c, input logic f, input logic a0, input logic o0, input logic [W-1:0] x0,
                      input logic a1, input logic o1, input logic [W-1:0] x1);
    logic idle, g, acc, op;
    logic [W-1:0] dat;
    @(negedge clk);
    clr = c; flush = f; v0 = a0; op0 = o0; d0 = x0; v1 = a1; op1 = o1; d1 = x1;
    #1;
    idle = cyc >= free_at && !c;
    if (idle) begin
      check("empty", empty, ref_stk.size() == 0);
      check("full", full, ref_stk.size() == 4);
    end
    check("stk_en", stk_en, cyc == issue_at && !c);
    check("stk_clr_n", stk_clr_n, !(c || cyc == flush_at));
    if (cyc == issue_at && !c) begin
      check("stk_con", stk_con, {1'b0, iss_op});
      if (!iss_op) check("stk_din", stk_din, iss_data);
    end else check("stk_con_idle", stk_con, 2'b10);
    if (c) check("stk_din_clr", stk_din, 0);
    g = (a0 && a1) ? !last : a1;
    acc = idle && !f && (a0 || a1);
    check("ready", {req1_ready, req0_ready}, acc ? (g ? 2'b10 : 2'b01) : 2'b00);
    if (c) begin
      sb.delete(); ref_stk.delete();
      free_at = cyc + 1; issue_at = -1; flush_at = -1; last = 1'b1; n_err = 0;
    end else if (idle && f) begin
      ref_stk.delete(); flush_at = cyc + 1; free_at = cyc + 2;
    end else if (acc) begin
      last = g; op = g ? o1 : o0; dat = g ? x1 : x0;
      if (op ? ref_stk.size() == 0 : ref_stk.size() == 4) begin
        sb.push_back('{cyc + 1, g, 1'b1, '0}); free_at = cyc + 1; n_err++;
      end else if (op) begin
        sb.push_back('{cyc + 3, g, 1'b0, ref_stk.pop_back()});
        issue_at = cyc + 1; free_at = cyc + 3; iss_op = 1'b1;
      end else begin
        ref_stk.push_back(dat);
        sb.push_back('{cyc + 2, g, 1'b0, '0});
        issue_at = cyc + 1; free_at = cyc + 2; iss_op = 1'b0; iss_data = dat;
      end
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic one(input logic o, input logic [W-1:0] x);
    step(0, 0, 1, o, x, 0, 0, '0);
    repeat (3) idle_step();
  endtask

  task automatic check_errcnt();
`ifdef STACK_ARB_ERRCNT_EN
    check("err_cnt", err_cnt, n_err > 255 ? 255 : n_err);
`else
    check("err_cnt", err_cnt, 0);
`endif
  endtask

  // response monitor: pops the scoreboard whenever the DUT presents a response
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rsp_valid) begin
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("rsp", {cyc, rsp_id, rsp_err, rsp_data}, {e.at, e.id, e.err, e.data});
      end
    end else if (sb.size() > 0 && sb[0].at <= cyc) begin
      check("rsp_missing", 0, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    repeat (2) step(1, 0, 0, 0, '0, 0, 0, '0);
    idle_step();
    check("rst_outputs", {rsp_valid, rsp_id, rsp_err, rsp_data, err_cnt, full, empty}, 2'b01);
    // both requesters pushing continuously: grants alternate starting with req0
    repeat (6) step(0, 0, 1, 0, 8'h30 + 8'(cyc), 1, 0, 8'h60 + 8'(cyc));
    repeat (3) idle_step();
    // flush and a request together: flush wins, request accepted afterwards
    step(0, 1, 1, 0, 8'h55, 0, 0, '0);
    repeat (2) step(0, 0, 1, 0, 8'h55, 0, 0, '0);
    repeat (3) idle_step();
    repeat (2) step(1, 0, 0, 0, '0, 0, 0, '0);
    // underflow, single push/pop, overflow and LIFO order
    one(1, '0);
    idle_step();
    check_errcnt();
    one(0, 8'h11);
    one(1, '0);
    one(0, 8'hA1); one(0, 8'hA2); one(0, 8'hA3); one(0, 8'hA4); one(0, 8'hA5);
    one(1, '0);
    check_errcnt();
    // clear while the pop result is being captured
    one(0, 8'h77);
    step(0, 0, 1, 1, '0, 0, 0, '0);
    idle_step();
    step(1, 0, 0, 0, '0, 0, 0, '0);
    repeat (3) idle_step();
    check_errcnt();
    repeat (600)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, W'($urandom));
    repeat (6) idle_step();
    check("scoreboard_drained", sb.size(), 0);
    check_errcnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter WIDTH, default 8: stack data width in bits.
REQ-002 Parameter DEPTH, default 2: log2 of stack entries (4 entries).
REQ-003 clk  in  1: single clock; all state changes on posedge.
REQ-004 clr  in  1: synchronous reset, active-high.
REQ-005 flush  in  1: request to empty the stack.
REQ-006 req0_valid, req1_valid  in  1 each: requester has an operation pending.
REQ-007 req0_op, req1_op  in  1 each: 0 = push, 1 = pop.
REQ-008 req0_data, req1_data  in  WIDTH each: push data.
REQ-009 req0_ready, req1_ready  out  1 each: request accepted this cycle.
REQ-010 rsp_valid  out  1: one-cycle completion pulse.
REQ-011 rsp_id  out  1: requester index of the completed operation.
REQ-012 rsp_err  out  1: completed operation was rejected (overflow/underflow).
REQ-013 rsp_data  out  WIDTH: pop result; 0 for pushes and errors.
REQ-014 stk_en, stk_con[1:0], stk_din[WIDTH-1:0], stk_clr_n  out: stack command port (con 00 push, 01 pop, 10 idle; clr_n active-low).
REQ-015 stk_dout  in  WIDTH: stack pop data, valid one cycle after pop issue.
REQ-016 full, empty  out  1 each: occupancy flags.
REQ-017 err_cnt  out  8: saturating error count.

Function
REQ-018 FSM states: IDLE, ISSUE, CAPT, FLUSH.
REQ-019 IDLE: flush high -> FLUSH, no ready asserted (flush beats requests).
REQ-020 IDLE, no flush, any valid: one ready asserted combinationally; winner's op/data/id latched.
REQ-021 Arbitration round-robin: on tie, grant requester other than last_grant; single valid always wins.
REQ-022 Accepted push with full, or pop with empty: no stack command; stay IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-023 Accepted legal op -> ISSUE for one cycle: stk_en=1, stk_con=00 (push, stk_din=latched data) or 01 (pop); occupancy +1/-1.
REQ-024 ISSUE push -> IDLE; rsp_valid next cycle (accept at k, response at k+2).
REQ-025 ISSUE pop -> CAPT; CAPT registers stk_dout; -> IDLE; rsp_valid next cycle with data (accept at k, response at k+3).
REQ-026 FLUSH: one cycle, stk_clr_n=0, occupancy=0, -> IDLE; no rsp.
REQ-027 Outside ISSUE: stk_en=0, stk_con=10; stk_clr_n=0 only in FLUSH or while clr high.
REQ-028 ready only in IDLE; rsp_valid may coincide with a new accept.
REQ-029 Occupancy counter DEPTH+1 bits, range 0..2**DEPTH; full = occ==2**DEPTH, empty = occ==0.
REQ-030 rsp_* registered, rsp_valid high exactly one cycle per accepted request.

Reset
REQ-031 clr high: state IDLE, occupancy 0, last_grant=1, rsp_*=0, err_cnt=0, full=0, empty=1, stk_en=0, stk_con=10, stk_din=0, stk_clr_n=0.
REQ-032 clr mid-operation aborts it; no rsp issued for the aborted request.

Configuration
REQ-033 STACK_ARB_ERRCNT_EN defined: err_cnt increments on each rsp_err pulse, saturates at 255, cleared by clr only.
REQ-034 STACK_ARB_ERRCNT_EN undefined: err_cnt tied to 0, no counter logic.

Structure
REQ-035 Shared package: state enum, stack op codes (PUSH 00, POP 01, IDLE 10), requester-index type.
REQ-036 One sub-module: rr_arb2 (two-way round-robin arbiter, grant and last_grant update).
REQ-037 Stack instantiated outside; stack_arb drives only its command port.

Verification
REQ-038 Reset, req0 push 0x11 -> ready0 at k, stk_con=00/stk_din=0x11 at k+1, rsp_valid id=0 err=0 at k+2, empty=0.
REQ-039 Push 0xA1,0xA2,0xA3,0xA4, fifth push 0xA5 -> rsp_err=1, no stk_en, full=1; pop returns 0xA4 at accept+3.
REQ-040 Pop on empty after reset -> rsp_err=1, rsp_data=0, err_cnt=1 (macro on) / 0 (off).
REQ-041 Both valid continuously, pushes -> grants alternate 0,1,0,1, first grant to req0.
REQ-042 flush and req0_valid together in IDLE with occ=3 -> FLUSH, stk_clr_n=0 one cycle, empty=1, req0 accepted next IDLE cycle.
REQ-043 clr asserted during CAPT -> no rsp_valid, all outputs at reset values next cycle.
